mem_wb_pipe: RTL and testbench

//  Producer end of the EX-stage forwarding path: EX/MEM and MEM/WB pipeline registers plus data-memory access sequencing.

---
 rtl/mem_wb_pipe.sv | 149 ++++++++++++++
 tb/tb_mem_wb_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with data-memory
// access sequencing. Feeds the EX-stage forwarding path from both the MEM
// and WB stages. Freezes the front of the pipe while an access is pending.
//
// Handshake (dmem req/ack): dmem_req rises when a load/store sits in MEM and
// stays high, with dmem_we/dmem_addr/dmem_wdata stable, until the cycle in
// which dmem_ack is seen (transfer completes on that edge) or the wait
// counter expires (access abandoned). dmem_ack outside dmem_req is ignored,
// and dmem_rdata is only meaningful in the ack cycle.
module mem_wb_pipe #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_ex,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        MemStall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_err
);

  // Last counter value before an unacknowledged access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic {
    M_IDLE = 1'b0,
    M_ACC  = 1'b1
  } mem_state_e;

  // State is kept as a named signal so checkers can bind to it directly.
  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        stall_c;
  logic        timeout_c;
  logic        req_c;

  logic [31:0] wdata_mem;
  logic        memwrite_mem;
  logic        memtoreg_mem;

  // FSM state and wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= M_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state follows the instruction entering MEM; counter runs while waiting.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_c    = 1'b0;
    timeout_c  = 1'b0;
    req_c      = 1'b0;
    case (state_q)
      M_IDLE: ;
      M_ACC: begin
        req_c = 1'b1;
        if (!dmem_ack) begin
          if (wait_cnt_q == TMO_LAST) begin
            timeout_c = 1'b1;
          end else begin
            stall_c    = 1'b1;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (!stall_c) begin
      state_d    = (valid_ex && (MemRead_ex || MemWrite_ex)) ? M_ACC : M_IDLE;
      wait_cnt_d = 8'd0;
    end
  end

  // Reset drops the request and stall in the very cycle it is sampled.
  always_comb begin
    MemStall   = stall_c && !reset;
    dmem_req   = req_c && !reset;
    dmem_we    = dmem_req && memwrite_mem;
    dmem_addr  = ALUResult_mem;
    dmem_wdata = wdata_mem;
  end

  // EX/MEM register: captures EX whenever MEM can advance; bubbles clear control.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_mem <= 32'd0;
      wdata_mem     <= 32'd0;
      rdAddr_mem    <= 5'd0;
      RegWrite_mem  <= 1'b0;
      memwrite_mem  <= 1'b0;
      memtoreg_mem  <= 1'b0;
    end else if (!stall_c) begin
      ALUResult_mem <= ALUResult_ex;
      wdata_mem     <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      RegWrite_mem  <= valid_ex && RegWrite_ex;
      memwrite_mem  <= valid_ex && MemWrite_ex;
      memtoreg_mem  <= valid_ex && MemtoReg_ex;
    end
  end

  // MEM/WB register: advances with MEM; a stall inserts a write-disabled bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteData_wb <= 32'd0;
      rdAddr_wb       <= 5'd0;
      RegWrite_wb     <= 1'b0;
    end else if (!stall_c) begin
      RegWriteData_wb <= memtoreg_mem ? dmem_rdata : ALUResult_mem;
      rdAddr_wb       <= rdAddr_mem;
      RegWrite_wb     <= RegWrite_mem && !timeout_c;
    end else begin
      RegWrite_wb     <= 1'b0;
    end
  end

  // Abandoned access is flagged for one cycle after the timeout edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= timeout_c;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe (built with ACK_TIMEOUT = 4).
module tb_mem_wb_pipe;

  logic        clk;
  logic        reset;
  logic        valid_ex;
  logic [31:0] ALUResult_ex;
  logic [31:0] MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex;
  logic        MemRead_ex;
  logic        MemWrite_ex;
  logic        MemtoReg_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic        MemStall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_err;

  int n_cmp;
  int n_err;

  mem_wb_pipe #(.ACK_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_ex        (valid_ex),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .rdAddr_ex       (rdAddr_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb),
    .MemStall        (MemStall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .mem_err         (mem_err)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
    valid_ex        = v;
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
    rdAddr_ex       = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemtoReg_ex     = m2r;
    #1;
  endtask

  task automatic bubble();
    drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_mem"}, ALUResult_mem, 32'h0);
    check({tag, "_rd_mem"}, {27'd0, rdAddr_mem}, 32'h0);
    check({tag, "_rw_mem"}, {31'd0, RegWrite_mem}, 32'h0);
    check({tag, "_data_wb"}, RegWriteData_wb, 32'h0);
    check({tag, "_rd_wb"}, {27'd0, rdAddr_wb}, 32'h0);
    check({tag, "_rw_wb"}, {31'd0, RegWrite_wb}, 32'h0);
    check({tag, "_stall"}, {31'd0, MemStall}, 32'h0);
    check({tag, "_req"}, {31'd0, dmem_req}, 32'h0);
    check({tag, "_we"}, {31'd0, dmem_we}, 32'h0);
    check({tag, "_addr"}, dmem_addr, 32'h0);
    check({tag, "_wdata"}, dmem_wdata, 32'h0);
    check({tag, "_err"}, {31'd0, mem_err}, 32'h0);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    bubble();

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("reset");

    // 1: ALU op flows MEM then WB
    drive_ex(1'b1, 32'h12, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bubble();
    check("t1_alu_mem", ALUResult_mem, 32'h12);
    check("t1_rw_mem", {31'd0, RegWrite_mem}, 32'd1);
    check("t1_rd_mem", {27'd0, rdAddr_mem}, 32'd5);
    check("t1_req", {31'd0, dmem_req}, 32'd0);
    check("t1_stall", {31'd0, MemStall}, 32'd0);
    tick();
    check("t1_data_wb", RegWriteData_wb, 32'h12);
    check("t1_rd_wb", {27'd0, rdAddr_wb}, 32'd5);
    check("t1_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    check("t1_rw_mem_bubble", {31'd0, RegWrite_mem}, 32'd0);
    tick();
    check("t1_rw_wb_bubble", {31'd0, RegWrite_wb}, 32'd0);

    // 2: zero-wait load
    drive_ex(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    check("t2_req", {31'd0, dmem_req}, 32'd1);
    check("t2_we", {31'd0, dmem_we}, 32'd0);
    check("t2_addr", dmem_addr, 32'h100);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("t2_stall", {31'd0, MemStall}, 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    check("t2_data_wb", RegWriteData_wb, 32'hDEADBEEF);
    check("t2_rd_wb", {27'd0, rdAddr_wb}, 32'd7);
    check("t2_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    check("t2_req_after", {31'd0, dmem_req}, 32'd0);

    // 3: store acknowledged after three wait cycles
    drive_ex(1'b1, 32'h40, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    bubble();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_stall_%0d", i), {31'd0, MemStall}, 32'd1);
      check($sformatf("t3_req_%0d", i), {31'd0, dmem_req}, 32'd1);
      check($sformatf("t3_we_%0d", i), {31'd0, dmem_we}, 32'd1);
      check($sformatf("t3_addr_%0d", i), dmem_addr, 32'h40);
      check($sformatf("t3_wdata_%0d", i), dmem_wdata, 32'h55);
      check($sformatf("t3_rw_wb_%0d", i), {31'd0, RegWrite_wb}, 32'd0);
      tick();
    end
    dmem_ack = 1'b1;
    #1;
    check("t3_stall_ack", {31'd0, MemStall}, 32'd0);
    check("t3_we_ack", {31'd0, dmem_we}, 32'd1);
    check("t3_addr_ack", dmem_addr, 32'h40);
    tick();
    dmem_ack = 1'b0;
    #1;
    check("t3_rw_wb", {31'd0, RegWrite_wb}, 32'd0);
    check("t3_err", {31'd0, mem_err}, 32'd0);
    check("t3_req_after", {31'd0, dmem_req}, 32'd0);

    // 4: load with no ack times out; the waiting ALU op then enters MEM
    drive_ex(1'b1, 32'h200, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(1'b1, 32'h33, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_stall_%0d", i), {31'd0, MemStall}, 32'd1);
      check($sformatf("t4_err_%0d", i), {31'd0, mem_err}, 32'd0);
      tick();
    end
    check("t4_stall_tmo", {31'd0, MemStall}, 32'd0);
    check("t4_req_tmo", {31'd0, dmem_req}, 32'd1);
    check("t4_err_tmo", {31'd0, mem_err}, 32'd0);
    tick();
    bubble();
    check("t4_err_pulse", {31'd0, mem_err}, 32'd1);
    check("t4_rw_wb", {31'd0, RegWrite_wb}, 32'd0);
    check("t4_alu_mem_next", ALUResult_mem, 32'h33);
    check("t4_rd_mem_next", {27'd0, rdAddr_mem}, 32'd3);
    check("t4_req_next", {31'd0, dmem_req}, 32'd0);
    tick();
    check("t4_err_clear", {31'd0, mem_err}, 32'd0);
    check("t4_data_wb_next", RegWriteData_wb, 32'h33);
    check("t4_rd_wb_next", {27'd0, rdAddr_wb}, 32'd3);
    check("t4_rw_wb_next", {31'd0, RegWrite_wb}, 32'd1);

    // 5: reset during a load wait; late ack is ignored
    drive_ex(1'b1, 32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    tick();
    check("t5_stall_wait", {31'd0, MemStall}, 32'd1);
    reset = 1'b1;
    #1;
    check("t5_req_in_reset", {31'd0, dmem_req}, 32'd0);
    check("t5_stall_in_reset", {31'd0, MemStall}, 32'd0);
    tick();
    reset      = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hAAAA5555;
    #1;
    check_all_zero("t5");
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    check("t5_rw_wb_late", {31'd0, RegWrite_wb}, 32'd0);
    check("t5_data_wb_late", RegWriteData_wb, 32'h0);
    check("t5_req_late", {31'd0, dmem_req}, 32'd0);

    // 6: ALU, 2-wait load, ALU keep order with one write pulse each
    drive_ex(1'b1, 32'h11, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_ex(1'b1, 32'h400, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    drive_ex(1'b1, 32'h22, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_a_data_wb", RegWriteData_wb, 32'h11);
    check("t6_a_rd_wb", {27'd0, rdAddr_wb}, 32'd1);
    check("t6_a_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    check("t6_stall_0", {31'd0, MemStall}, 32'd1);
    tick();
    check("t6_rw_wb_w0", {31'd0, RegWrite_wb}, 32'd0);
    check("t6_stall_1", {31'd0, MemStall}, 32'd1);
    tick();
    check("t6_rw_wb_w1", {31'd0, RegWrite_wb}, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE0002;
    #1;
    check("t6_stall_ack", {31'd0, MemStall}, 32'd0);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    check("t6_b_data_wb", RegWriteData_wb, 32'hCAFE0002);
    check("t6_b_rd_wb", {27'd0, rdAddr_wb}, 32'd2);
    check("t6_b_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    check("t6_c_alu_mem", ALUResult_mem, 32'h22);
    tick();
    check("t6_c_data_wb", RegWriteData_wb, 32'h22);
    check("t6_c_rd_wb", {27'd0, rdAddr_wb}, 32'd4);
    check("t6_c_rw_wb", {31'd0, RegWrite_wb}, 32'd1);
    tick();
    check("t6_rw_wb_idle", {31'd0, RegWrite_wb}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
